// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: light colours,
// FSM state encoding and the dwell counter width.
package tlc_pkg;

  localparam int CNT_W = 8;

  typedef logic [1:0] colour_t;

  localparam colour_t RED    = 2'd0;
  localparam colour_t YELLOW = 2'd1;
  localparam colour_t GREEN  = 2'd2;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // highway green, waiting for a country-road car
    S1 = 3'd1,  // highway yellow
    S2 = 3'd2,  // all red
    S3 = 3'd3,  // country road green
    S4 = 3'd4   // country road yellow
  } tlc_state_e;

  // States that leave on a dwell timeout rather than on the sensor.
  function automatic logic is_timed(tlc_state_e s);
    return (s == S1) || (s == S2) || (s == S4);
  endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Dwell counter: synchronous clear to zero, counts while enabled, and
// flags done on the last cycle of a delay-cycle dwell.
module tlc_dwell_timer
  import tlc_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] delay,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // delay >= 1, so delay-1 never underflows and count never wraps.
  assign done = en && (count_q == delay - W'(1));

endmodule

// File: rtl/traffic_light_controller.sv
// Highway / country-road traffic light controller: five-state Moore FSM,
// with yellow and all-red dwell times set by parameters.
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int unsigned Y2RDELAY = 3,
  parameter int unsigned R2GDELAY = 2
) (
  input  logic       X,
  output logic [1:0] CR,
  output logic [1:0] HW,
  input  logic       clk,
  input  logic       clear
);

  if (Y2RDELAY < 1 || Y2RDELAY > 255) begin : g_bad_y2r
    $error("Y2RDELAY must be in 1..255");
  end
  if (R2GDELAY < 1 || R2GDELAY > 255) begin : g_bad_r2g
    $error("R2GDELAY must be in 1..255");
  end

  localparam logic [CNT_W-1:0] Y2R = CNT_W'(Y2RDELAY);
  localparam logic [CNT_W-1:0] R2G = CNT_W'(R2GDELAY);

  tlc_state_e       state_q, state_d;
  logic             timed;
  logic             done;
  logic [CNT_W-1:0] delay_sel;

  assign timed     = is_timed(state_q);
  assign delay_sel = (state_q == S2) ? R2G : Y2R;

  tlc_dwell_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (clear),
    .clr   (state_d != state_q),
    .en    (timed),
    .delay (delay_sel),
    .done  (done)
  );

  // An unknown X evaluates false in both tests, so it reads as "no change".
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0:      if (X)    state_d = S1;
      S1:      if (done) state_d = S2;
      S2:      if (done) state_d = S3;
      S3:      if (!X)   state_d = S4;
      S4:      if (done) state_d = S0;
      default:           state_d = S0;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    HW = RED;
    CR = RED;
    unique case (state_q)
      S0:      HW = GREEN;
      S1:      HW = YELLOW;
      S3:      CR = GREEN;
      S4:      CR = YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Random and directed stimulus for two controllers (default delays and 1/1),
// checked every cycle against a timestamp-based reference model.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       clear;
  logic       X = 1'b0;
  logic [1:0] hw0, cr0, hw1, cr1;

  int n_chk = 0;
  int n_err = 0;

  traffic_light_controller dut (
    .X(X), .CR(cr0), .HW(hw0), .clk(clk), .clear(clear)
  );

  traffic_light_controller #(.Y2RDELAY(1), .R2GDELAY(1)) dut_fast (
    .X(X), .CR(cr1), .HW(hw1), .clk(clk), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0..4 in the light sequence plus the edge number
  // at which the phase was entered; timed phases leave when their age hits
  // the dwell time.
  int ecnt = 0;
  int ph[2] = '{0, 0};
  int t0[2] = '{0, 0};

  function automatic int dwell(int k, int p);
    if (k == 1) return 1;
    return (p == 2) ? 2 : 3;
  endfunction

  function automatic int exp_hw(int p);
    return (p == 0) ? 2 : (p == 1) ? 1 : 0;
  endfunction

  function automatic int exp_cr(int p);
    return (p == 3) ? 2 : (p == 4) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0;
        t0[k] = ecnt;
      end
    end else begin
      ecnt++;
      for (int k = 0; k < 2; k++) begin
        case (ph[k])
          0: if (X) begin ph[k] = 1; t0[k] = ecnt; end
          3: if (!X) begin ph[k] = 4; t0[k] = ecnt; end
          default:
            if (ecnt - t0[k] == dwell(k, ph[k])) begin
              ph[k] = (ph[k] + 1) % 5;
              t0[k] = ecnt;
            end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("hw", int'(hw0), exp_hw(ph[0]));
    chk("cr", int'(cr0), exp_cr(ph[0]));
    chk("hw_fast", int'(hw1), exp_hw(ph[1]));
    chk("cr_fast", int'(cr1), exp_cr(ph[1]));
    chk("mutex", int'(hw0 != 2'd0 && cr0 != 2'd0), 0);
    chk("mutex_fast", int'(hw1 != 2'd0 && cr1 != 2'd0), 0);
  end

  // Advance n rising edges and land 2 time units after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_pulse_check(input string tag);
    clear = 1'b1;
    #1;
    chk({tag, "_hw"}, int'(hw0), 2);
    chk({tag, "_cr"}, int'(cr0), 0);
    chk({tag, "_hw_fast"}, int'(hw1), 2);
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    #3;
    chk("rst_hw", int'(hw0), 2);
    chk("rst_cr", int'(cr0), 0);
    #4 clear = 1'b0;                // t=7
    #5 X = 1'b1;                    // t=12
    #8;                             // t=20
    chk("s1_hw", int'(hw0), 1);
    chk("s1_cr", int'(cr0), 0);
    #30;                            // t=50
    chk("s2_hw", int'(hw0), 0);
    chk("s2_cr", int'(cr0), 0);
    #7 X = 1'b0;                    // t=57
    #13;                            // t=70
    chk("s3_cr", int'(cr0), 2);
    chk("s3_hw", int'(hw0), 0);
    #10;                            // t=80
    chk("s4_cr", int'(cr0), 1);
    #30;                            // t=110
    chk("s0_hw", int'(hw0), 2);
    chk("s0_cr", int'(cr0), 0);

    // Idle highway-green with no cars.
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    X = 1'b0;
    cyc(20);

    // Car holds the sensor: country road stays green until it leaves.
    X = 1'b1;
    cyc(15);
    X = 1'b0;
    cyc(8);

    // One-cycle pulse still runs the whole sequence.
    X = 1'b1;
    cyc(1);
    X = 1'b0;
    cyc(15);

    // Abort from the all-red state.
    X = 1'b1;
    for (int i = 0; i < 50 && ph[0] != 2; i++) cyc(1);
    chk("reach_s2", ph[0], 2);
    X = 1'b0;
    clear_pulse_check("abort");
    cyc(3);
    X = 1'b1;
    cyc(12);
    X = 1'b0;
    cyc(10);

    // Random sensor activity with occasional asynchronous clears.
    repeat (3000) begin
      X = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 149) == 0) begin
        #1;
        clear_pulse_check("rnd_clr");
      end else begin
        cyc($urandom_range(1, 4));
      end
    end

    X = 1'b0;
    cyc(10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
